// File: rtl/p_mem_pkg.sv
// Opcode constants, FSM state encoding and opcode decode helpers shared by the
// memory-access stage and its load-extension unit.
package p_mem_pkg;

    localparam logic [4:0] INS_EMP = 5'd0;
    localparam logic [4:0] INS_ADD = 5'd1;
    localparam logic [4:0] INS_SUB = 5'd2;
    localparam logic [4:0] INS_JAL = 5'd3;
    localparam logic [4:0] INS_LB  = 5'd8;
    localparam logic [4:0] INS_LH  = 5'd9;
    localparam logic [4:0] INS_LW  = 5'd10;
    localparam logic [4:0] INS_LBU = 5'd11;
    localparam logic [4:0] INS_LHU = 5'd12;
    localparam logic [4:0] INS_SB  = 5'd13;
    localparam logic [4:0] INS_SH  = 5'd14;
    localparam logic [4:0] INS_SW  = 5'd15;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_XFER = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    function automatic logic is_load(input logic [4:0] op);
        return (op == INS_LB) || (op == INS_LH) || (op == INS_LW) ||
               (op == INS_LBU) || (op == INS_LHU);
    endfunction

    function automatic logic is_store(input logic [4:0] op);
        return (op == INS_SB) || (op == INS_SH) || (op == INS_SW);
    endfunction

    function automatic logic is_mem(input logic [4:0] op);
        return is_load(op) || is_store(op);
    endfunction

    function automatic logic [2:0] byte_count(input logic [4:0] op);
        case (op)
            INS_LB, INS_LBU, INS_SB: return 3'd1;
            INS_LH, INS_LHU, INS_SH: return 3'd2;
            INS_LW, INS_SW:          return 3'd4;
            default:                 return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/p_mem_ldext.sv
// Sign/zero extension of an assembled little-endian load word according to
// the load opcode; purely combinational.
module p_mem_ldext
    import p_mem_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [4:0]  opcode,
    output logic [31:0] data_out
);

    always_comb begin
        data_out = data_in;
        case (opcode)
            INS_LB:  data_out = {{24{data_in[7]}}, data_in[7:0]};
            INS_LBU: data_out = {24'h0, data_in[7:0]};
            INS_LH:  data_out = {{16{data_in[15]}}, data_in[15:0]};
            INS_LHU: data_out = {16'h0, data_in[15:0]};
            default: data_out = data_in;
        endcase
    end

endmodule

// File: rtl/p_mem.sv
// Memory-access pipeline stage: passes ALU results through and runs loads and
// stores as little-endian byte sequences on an 8-bit request/grant port.
module p_mem
    import p_mem_pkg::*;
(
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [4:0]  opcode,
    input  logic        we,
    input  logic [31:0] w_addr,
    input  logic [31:0] w_data,
    input  logic [31:0] addr,
    output logic        out_we,
    output logic [31:0] out_w_addr,
    output logic [31:0] out_w_data,
    output logic        busy_out,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [31:0] mem_a,
    output logic [7:0]  mem_dout,
    input  logic        mem_gnt,
    input  logic [7:0]  mem_din
);

    mem_state_e  state_q, state_d;
    logic [4:0]  op_q, op_d;
    logic        we_q, we_d;
    logic [31:0] w_addr_q, w_addr_d;
    logic [31:0] w_data_q, w_data_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic [2:0]  issue_cnt_q, issue_cnt_d;
    logic [2:0]  recv_cnt_q, recv_cnt_d;
    logic        rd_pend_q, rd_pend_d;

    logic [2:0]  n_bytes;
    logic        lat_store;
    logic [31:0] ext_data;

    assign n_bytes   = byte_count(op_q);
    assign lat_store = is_store(op_q);

    p_mem_ldext u_ldext (
        .data_in  (data_q),
        .opcode   (op_q),
        .data_out (ext_data)
    );

    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d     = state_q;
        op_d        = op_q;
        we_d        = we_q;
        w_addr_d    = w_addr_q;
        w_data_d    = w_data_q;
        addr_d      = addr_q;
        data_d      = data_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;
        rd_pend_d   = 1'b0;

        out_we      = 1'b0;
        out_w_addr  = 32'h0;
        out_w_data  = 32'h0;
        busy_out    = 1'b0;
        mem_req     = 1'b0;
        mem_wr      = 1'b0;
        mem_a       = 32'h0;
        mem_dout    = 8'h0;

        // A byte granted last cycle lands in the next lane, even while rdy_in is low.
        if (rd_pend_q && (state_q != MEM_IDLE)) begin
            data_d[{recv_cnt_q[1:0], 3'b000} +: 8] = mem_din;
            recv_cnt_d = recv_cnt_q + 3'd1;
        end

        case (state_q)
            MEM_IDLE: begin
                if (is_mem(opcode)) begin
                    busy_out = 1'b1;
                    if (rdy_in) begin
                        op_d        = opcode;
                        we_d        = we;
                        w_addr_d    = w_addr;
                        w_data_d    = w_data;
                        addr_d      = addr;
                        data_d      = 32'h0;
                        issue_cnt_d = 3'd0;
                        recv_cnt_d  = 3'd0;
                        state_d     = MEM_XFER;
                    end
                end else begin
                    out_we     = we;
                    out_w_addr = w_addr;
                    out_w_data = w_data;
                end
            end

            MEM_XFER: begin
                busy_out = 1'b1;
                if (rdy_in) begin
                    mem_req = 1'b1;
                    mem_wr  = lat_store;
                    mem_a   = addr_q + 32'(issue_cnt_q);
                    if (lat_store) begin
                        mem_dout = w_data_q[{issue_cnt_q[1:0], 3'b000} +: 8];
                    end
                    if (mem_gnt) begin
                        issue_cnt_d = issue_cnt_q + 3'd1;
                        rd_pend_d   = !lat_store;
                        if (issue_cnt_d == n_bytes) begin
                            state_d = lat_store ? MEM_DONE : MEM_WAIT;
                        end
                    end
                end
            end

            MEM_WAIT: begin
                busy_out = 1'b1;
                if (rdy_in && (recv_cnt_d == n_bytes)) begin
                    state_d = MEM_DONE;
                end
            end

            MEM_DONE: begin
                if (!lat_store) begin
                    out_we     = we_q;
                    out_w_addr = w_addr_q;
                    out_w_data = ext_data;
                end
                if (rdy_in) begin
                    state_d = MEM_IDLE;
                end
            end

            default: state_d = MEM_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q     <= MEM_IDLE;
            op_q        <= INS_EMP;
            we_q        <= 1'b0;
            w_addr_q    <= 32'h0;
            w_data_q    <= 32'h0;
            addr_q      <= 32'h0;
            data_q      <= 32'h0;
            issue_cnt_q <= 3'd0;
            recv_cnt_q  <= 3'd0;
            rd_pend_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            we_q        <= we_d;
            w_addr_q    <= w_addr_d;
            w_data_q    <= w_data_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
            rd_pend_q   <= rd_pend_d;
        end
    end

endmodule
